// File: rtl/mantissa_normalizer.sv
// rtl/mantissa_normalizer.sv - multi-cycle left normalizer for FP mantissas
// One logarithmic shift stage per clock, with valid/ready handshakes on both sides.
module mantissa_normalizer #(
  parameter int WIDTH = 24,
  parameter int CW    = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out,
  output logic [CW:0]      Count,
  output logic             Zero,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam int IW = (CW > 1) ? $clog2(CW) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [CW:0]      cnt;
  logic [IW-1:0]    idx;
  logic             zero_r;

  int               stage_sh;
  logic [CW:0]      amt;
  logic [WIDTH-1:0] mask;
  logic             fire;
  logic [WIDTH-1:0] data_nx;
  logic [CW:0]      cnt_nx;

  // Stage idx shifts by 2**(CW-1-idx) when the top amt bits are all zero.
  always_comb begin
    stage_sh = CW - 1 - int'(idx);
    amt      = (CW+1)'(1) << stage_sh;
    mask     = ~({WIDTH{1'b1}} >> amt);
    fire     = (data & mask) == '0;
    data_nx  = fire ? (data << amt) : data;
    cnt_nx   = fire ? (cnt + amt) : cnt;
  end

  assign In_Ready  = (state == IDLE);
  assign Out_Valid = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      data   <= '0;
      cnt    <= '0;
      idx    <= '0;
      zero_r <= 1'b0;
      Out    <= '0;
      Count  <= '0;
      Zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            data   <= In;
            cnt    <= '0;
            zero_r <= (In == '0);
            idx    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          data <= data_nx;
          cnt  <= cnt_nx;
          idx  <= idx + 1'b1;
          if (idx == IW'(CW - 1)) begin
            // An all-zero input fires every stage; report WIDTH, not the raw sum.
            Out   <= data_nx;
            Count <= zero_r ? (CW+1)'(WIDTH) : cnt_nx;
            Zero  <= zero_r;
            state <= DONE;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
